// File: rtl/ptmch_pkg.sv
// ---------------------------------------------------------------------------
// ptmch_pkg
// Shared definitions for the ptmch SPI link: master FSM state encoding,
// SPI mode constants (mode 0, MSB first) and default frame parameters
// shared by the master and the receiver.
// Ports: none (package).
// ---------------------------------------------------------------------------
package ptmch_pkg;

    // SPI master FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } ptmch_spi_st_e;

    // SPI mode 0, MSB first
    localparam logic SPI_CPOL      = 1'b0;
    localparam logic SPI_CPHA      = 1'b0;
    localparam logic SPI_MSB_FIRST = 1'b1;

    // Default link parameters (16-bit words, 10 MHz SPI_CLK from 160 MHz)
    localparam int unsigned PTMCH_SPI_DW     = 16;
    localparam int unsigned PTMCH_SPI_CLKDIV = 8;
    localparam int unsigned PTMCH_SPI_CSGAP  = 4;

    // Larger of two unsigned values, used for counter sizing
    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ptmch_spi_mst_if.sv
// ---------------------------------------------------------------------------
// ptmch_spi_mst_if
// Request/data handshake and SPI pins of the ptmch SPI master.
//   TX_REQ   request, accepted when TX_RDY=1
//   TX_DATA  word to send (P_DW bits)
//   TX_RDY   master idle
//   TX_DONE  one-cycle pulse at frame end
//   SPI_CS / SPI_CLK / SPI_MOSI  serial link (mode 0)
// Modports: master (the SPI block), slave (requester / link observer).
// ---------------------------------------------------------------------------
interface ptmch_spi_mst_if
    import ptmch_pkg::*;
#(
    parameter int unsigned P_DW = PTMCH_SPI_DW
);
    logic            TX_REQ;
    logic [P_DW-1:0] TX_DATA;
    logic            TX_RDY;
    logic            TX_DONE;
    logic            SPI_CS;
    logic            SPI_CLK;
    logic            SPI_MOSI;

    modport master (
        input  TX_REQ, TX_DATA,
        output TX_RDY, TX_DONE, SPI_CS, SPI_CLK, SPI_MOSI
    );

    modport slave (
        output TX_REQ, TX_DATA,
        input  TX_RDY, TX_DONE, SPI_CS, SPI_CLK, SPI_MOSI
    );
endinterface

// File: rtl/ptmch_spi_tick.sv
// ---------------------------------------------------------------------------
// ptmch_spi_tick
// Loadable down-counter. Loading N makes tick_o high on the N-th cycle
// after the load edge, i.e. tick_o marks the last cycle of an N-cycle phase.
// The count parks at zero; it never wraps.
//   clk, rst_n   clock, async active-low reset
//   load_i       load load_val_i at the next edge
//   load_val_i   phase length in cycles (>=1)
//   tick_o       registered terminal-count tick
// ---------------------------------------------------------------------------
module ptmch_spi_tick #(
    parameter int unsigned P_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_i,
    input  logic [P_W-1:0] load_val_i,
    output logic           tick_o
);

    logic [P_W-1:0] cnt_q, cnt_d;
    logic           tick_q;

    // Next count: reload, else decrement down to zero and stay there
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - P_W'(1);
        end
    end

    // Tick is registered from the next count so it lines up with count==1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == P_W'(1));
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/ptmch_spi_mst.sv
// ---------------------------------------------------------------------------
// ptmch_spi_mst
// SPI master (mode 0, MSB first, one word per CS frame) in the CLK160M
// domain. Frame: SETUP (CS low, P_CSGAP cycles), P_DW bits of SPI_CLK
// low/high for P_CLKDIV cycles each, HOLD (CS low, P_CSGAP cycles),
// GAP (CS high, P_CSGAP cycles, TX_DONE on its first cycle), then IDLE.
//   CLK160M   system clock
//   RESET_N   async active-low reset
//   bus       ptmch_spi_mst_if.master (TX_* handshake and SPI pins)
// ---------------------------------------------------------------------------
module ptmch_spi_mst
    import ptmch_pkg::*;
#(
    parameter int unsigned P_DW     = PTMCH_SPI_DW,
    parameter int unsigned P_CLKDIV = PTMCH_SPI_CLKDIV,
    parameter int unsigned P_CSGAP  = PTMCH_SPI_CSGAP
) (
    input  logic                   CLK160M,
    input  logic                   RESET_N,
    ptmch_spi_mst_if.master        bus
);

    localparam int unsigned PH_W = $clog2(umax(P_CLKDIV, P_CSGAP) + 1);
    localparam int unsigned BC_W = $clog2(P_DW + 1);

    if (P_DW == 0 || P_CLKDIV == 0 || P_CSGAP == 0) begin : g_param_chk
        $error("ptmch_spi_mst: P_DW, P_CLKDIV and P_CSGAP must all be >= 1");
    end

    if (SPI_CPOL != 1'b0 || SPI_CPHA != 1'b0 || SPI_MSB_FIRST != 1'b1) begin : g_mode_chk
        $error("ptmch_spi_mst: only mode 0, MSB first is implemented");
    end

    ptmch_spi_st_e   state_q, state_d;
    logic [P_DW-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0] bcnt_q, bcnt_d;
    logic            cs_q, cs_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            rdy_q, rdy_d;
    logic            done_q, done_d;

    logic            accept_c;
    logic            last_bit_c;
    logic            ld_c;
    logic [PH_W-1:0] ld_val_c;
    logic            tick;

    assign accept_c   = bus.TX_REQ && rdy_q;
    assign last_bit_c = (bcnt_q == BC_W'(1));

    // Phase timer for SETUP, SPI_CLK half periods, HOLD and GAP
    ptmch_spi_tick #(
        .P_W (PH_W)
    ) u_tick (
        .clk        (CLK160M),
        .rst_n      (RESET_N),
        .load_i     (ld_c),
        .load_val_i (ld_val_c),
        .tick_o     (tick)
    );

    // State register
    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept_c)                    state_d = ST_SETUP;
            ST_SETUP: if (tick)                        state_d = ST_SHIFT;
            ST_SHIFT: if (tick && sclk_q && last_bit_c) state_d = ST_HOLD;
            ST_HOLD:  if (tick)                        state_d = ST_GAP;
            ST_GAP:   if (tick)                        state_d = ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values; timer reloads at every phase boundary
    always_comb begin
        shreg_d  = shreg_q;
        bcnt_d   = bcnt_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        rdy_d    = rdy_q;
        done_d   = 1'b0;
        ld_c     = 1'b0;
        ld_val_c = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    shreg_d  = bus.TX_DATA;
                    bcnt_d   = BC_W'(P_DW);
                    cs_d     = 1'b0;
                    mosi_d   = bus.TX_DATA[P_DW-1];
                    rdy_d    = 1'b0;
                    ld_c     = 1'b1;
                    ld_val_c = PH_W'(P_CSGAP);
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    sclk_d   = SPI_CPOL;
                    ld_c     = 1'b1;
                    ld_val_c = PH_W'(P_CLKDIV);
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    ld_c     = 1'b1;
                    ld_val_c = PH_W'(P_CLKDIV);
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (last_bit_c) begin
                            // MOSI keeps the last bit through HOLD
                            ld_val_c = PH_W'(P_CSGAP);
                        end else begin
                            shreg_d = shreg_q << 1;
                            mosi_d  = shreg_d[P_DW-1];
                            bcnt_d  = bcnt_q - BC_W'(1);
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    cs_d     = 1'b1;
                    mosi_d   = 1'b0;
                    done_d   = 1'b1;
                    ld_c     = 1'b1;
                    ld_val_c = PH_W'(P_CSGAP);
                end
            end
            ST_GAP: begin
                if (tick) begin
                    rdy_d = 1'b1;
                end
            end
            default: begin
                cs_d   = 1'b1;
                sclk_d = SPI_CPOL;
                mosi_d = 1'b0;
                rdy_d  = 1'b1;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            shreg_q <= '0;
            bcnt_q  <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= SPI_CPOL;
            mosi_q  <= 1'b0;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
        end
    end

    assign bus.SPI_CS   = cs_q;
    assign bus.SPI_CLK  = sclk_q;
    assign bus.SPI_MOSI = mosi_q;
    assign bus.TX_RDY   = rdy_q;
    assign bus.TX_DONE  = done_q;

endmodule

// File: tb/tb_ptmch_spi_mst.sv
// ---------------------------------------------------------------------------
// tb_ptmch_spi_mst
// Directed bench for ptmch_spi_mst: a default-parameter instance (A) and a
// P_DW=8 / P_CLKDIV=1 / P_CSGAP=1 instance (B). Negedge monitors log SPI_CLK
// rising edges (with MOSI), CS edges, TX_DONE and TX_RDY rises by cycle
// number; tasks compare against hand-computed cycle offsets from T0.
// ---------------------------------------------------------------------------
module tb_ptmch_spi_mst;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ptmch_spi_mst_if #(.P_DW(16)) bus_a ();
    ptmch_spi_mst_if #(.P_DW(8))  bus_b ();

    ptmch_spi_mst #(.P_DW(16), .P_CLKDIV(8), .P_CSGAP(4)) u_dut_a (
        .CLK160M (clk),
        .RESET_N (rst_n),
        .bus     (bus_a)
    );

    ptmch_spi_mst #(.P_DW(8), .P_CLKDIV(1), .P_CSGAP(1)) u_dut_b (
        .CLK160M (clk),
        .RESET_N (rst_n),
        .bus     (bus_b)
    );

    // Monitor A
    bit   bits_a[$];
    int   rise_a[$], done_a[$], csf_a[$], csr_a[$], rdyr_a[$];
    int   hichg_a = 0;
    logic pcs_a = 1'b1, psclk_a = 1'b0, pmosi_a = 1'b0, prdy_a = 1'b1;

    always @(negedge clk) begin
        if (bus_a.SPI_CLK === 1'b1 && psclk_a === 1'b0) begin
            rise_a.push_back(cyc);
            bits_a.push_back(bus_a.SPI_MOSI);
        end
        if (bus_a.TX_DONE === 1'b1) done_a.push_back(cyc);
        if (bus_a.SPI_CS === 1'b0 && pcs_a === 1'b1) csf_a.push_back(cyc);
        if (bus_a.SPI_CS === 1'b1 && pcs_a === 1'b0) csr_a.push_back(cyc);
        if (bus_a.TX_RDY === 1'b1 && prdy_a === 1'b0) rdyr_a.push_back(cyc);
        if (bus_a.SPI_CLK === 1'b1 && bus_a.SPI_MOSI !== pmosi_a) hichg_a++;
        pcs_a   = bus_a.SPI_CS;
        psclk_a = bus_a.SPI_CLK;
        pmosi_a = bus_a.SPI_MOSI;
        prdy_a  = bus_a.TX_RDY;
    end

    // Monitor B
    bit   bits_b[$];
    int   rise_b[$], done_b[$], rdyr_b[$];
    logic psclk_b = 1'b0, prdy_b = 1'b1;

    always @(negedge clk) begin
        if (bus_b.SPI_CLK === 1'b1 && psclk_b === 1'b0) begin
            rise_b.push_back(cyc);
            bits_b.push_back(bus_b.SPI_MOSI);
        end
        if (bus_b.TX_DONE === 1'b1) done_b.push_back(cyc);
        if (bus_b.TX_RDY === 1'b1 && prdy_b === 1'b0) rdyr_b.push_back(cyc);
        psclk_b = bus_b.SPI_CLK;
        prdy_b  = bus_b.TX_RDY;
    end

    task automatic clear_a();
        bits_a.delete(); rise_a.delete(); done_a.delete();
        csf_a.delete(); csr_a.delete(); rdyr_a.delete();
        hichg_a = 0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic test_reset();
        bus_a.TX_REQ = 1'b0; bus_a.TX_DATA = '0;
        bus_b.TX_REQ = 1'b0; bus_b.TX_DATA = '0;
        repeat (3) @(negedge clk);
        total++; if (bus_a.SPI_CS !== 1'b1)   begin bad++; $display("FAIL reset_cs got=%b want=1", bus_a.SPI_CS); end
        total++; if (bus_a.SPI_CLK !== 1'b0)  begin bad++; $display("FAIL reset_sclk got=%b want=0", bus_a.SPI_CLK); end
        total++; if (bus_a.SPI_MOSI !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b want=0", bus_a.SPI_MOSI); end
        total++; if (bus_a.TX_RDY !== 1'b1)   begin bad++; $display("FAIL reset_rdy got=%b want=1", bus_a.TX_RDY); end
        total++; if (bus_a.TX_DONE !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b want=0", bus_a.TX_DONE); end
        total++; if (bus_b.SPI_CS !== 1'b1 || bus_b.TX_RDY !== 1'b1) begin
            bad++; $display("FAIL reset_b cs/rdy got=%b%b want=11", bus_b.SPI_CS, bus_b.TX_RDY);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle();
        int errs = 0;
        clear_a();
        repeat (1000) begin
            @(negedge clk);
            if (bus_a.SPI_CS !== 1'b1 || bus_a.SPI_CLK !== 1'b0 ||
                bus_a.SPI_MOSI !== 1'b0 || bus_a.TX_DONE !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL idle_pins bad_cycles=%0d want=0", errs); end
        total++; if (done_a.size() != 0) begin bad++; $display("FAIL idle_done got=%0d want=0", done_a.size()); end
    endtask

    task automatic test_single();
        int t0;
        logic [15:0] w = '0;
        @(negedge clk);
        clear_a();
        bus_a.TX_DATA = 16'hA5C3; bus_a.TX_REQ = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        bus_a.TX_REQ = 1'b0;
        wait_until(t0 + 280);
        for (int i = 0; i < 16; i++) if (i < bits_a.size()) w = {w[14:0], bits_a[i]};
        total++; if (rise_a.size() != 16) begin bad++; $display("FAIL single_edges got=%0d want=16", rise_a.size()); end
        total++; if (w !== 16'hA5C3) begin bad++; $display("FAIL single_data got=%h want=a5c3", w); end
        total++; if (rise_a.size() == 0 || rise_a[0] - t0 + 1 != 13) begin
            bad++; $display("FAIL single_first_rise got=%0d want=13", rise_a.size() ? rise_a[0] - t0 + 1 : -1);
        end
        total++; if (csf_a.size() != 1 || csf_a[0] - t0 + 1 != 1) begin
            bad++; $display("FAIL single_cs_fall got=%0d want=1", csf_a.size() ? csf_a[0] - t0 + 1 : -1);
        end
        total++; if (csr_a.size() != 1 || csr_a[0] - t0 + 1 != 265) begin
            bad++; $display("FAIL single_cs_rise got=%0d want=265", csr_a.size() ? csr_a[0] - t0 + 1 : -1);
        end
        total++; if (done_a.size() != 1 || done_a[0] - t0 + 1 != 265) begin
            bad++; $display("FAIL single_done n=%0d at=%0d want n=1 at=265", done_a.size(), done_a.size() ? done_a[0] - t0 + 1 : -1);
        end
        total++; if (rdyr_a.size() != 1 || rdyr_a[0] - t0 + 1 != 269) begin
            bad++; $display("FAIL single_rdy got=%0d want=269", rdyr_a.size() ? rdyr_a[0] - t0 + 1 : -1);
        end
        total++; if (hichg_a != 0) begin bad++; $display("FAIL single_mosi_stable got=%0d want=0", hichg_a); end
    endtask

    task automatic test_back_to_back();
        int t0;
        logic [15:0] w1 = '0, w2 = '0;
        @(negedge clk);
        clear_a();
        bus_a.TX_DATA = 16'h0001; bus_a.TX_REQ = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        bus_a.TX_DATA = 16'h8000;
        wait_until(t0 + 269);
        bus_a.TX_REQ = 1'b0;
        wait_until(t0 + 269 + 280);
        for (int i = 0; i < 16; i++) if (i < bits_a.size()) w1 = {w1[14:0], bits_a[i]};
        for (int i = 16; i < 32; i++) if (i < bits_a.size()) w2 = {w2[14:0], bits_a[i]};
        total++; if (rise_a.size() != 32) begin bad++; $display("FAIL b2b_edges got=%0d want=32", rise_a.size()); end
        total++; if (w1 !== 16'h0001) begin bad++; $display("FAIL b2b_word1 got=%h want=0001", w1); end
        total++; if (w2 !== 16'h8000) begin bad++; $display("FAIL b2b_word2 got=%h want=8000", w2); end
        total++; if (done_a.size() != 2 || done_a[1] - done_a[0] != 269) begin
            bad++; $display("FAIL b2b_done n=%0d gap=%0d want n=2 gap=269", done_a.size(), done_a.size() == 2 ? done_a[1] - done_a[0] : -1);
        end
        total++; if (csf_a.size() != 2 || csr_a.size() < 1 || csf_a[1] - csr_a[0] != 5) begin
            bad++; $display("FAIL b2b_cs_high n=%0d got=%0d want=5", csf_a.size(), (csf_a.size() == 2 && csr_a.size() > 0) ? csf_a[1] - csr_a[0] : -1);
        end
        total++; if (csf_a.size() != 2 || csf_a[1] - t0 + 1 != 270) begin
            bad++; $display("FAIL b2b_second_cs got=%0d want=270", csf_a.size() == 2 ? csf_a[1] - t0 + 1 : -1);
        end
    endtask

    task automatic test_busy();
        int t0;
        logic [15:0] w = '0;
        @(negedge clk);
        clear_a();
        bus_a.TX_DATA = 16'h1234; bus_a.TX_REQ = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        bus_a.TX_REQ = 1'b0; bus_a.TX_DATA = 16'hFFFF;
        wait_until(t0 + 50);  bus_a.TX_REQ = 1'b1; @(negedge clk); bus_a.TX_REQ = 1'b0;
        wait_until(t0 + 100); bus_a.TX_REQ = 1'b1; repeat (3) @(negedge clk); bus_a.TX_REQ = 1'b0;
        wait_until(t0 + 200); bus_a.TX_REQ = 1'b1;
        wait_until(t0 + 260); bus_a.TX_REQ = 1'b0;
        wait_until(t0 + 400);
        for (int i = 0; i < 16; i++) if (i < bits_a.size()) w = {w[14:0], bits_a[i]};
        total++; if (rise_a.size() != 16) begin bad++; $display("FAIL busy_edges got=%0d want=16", rise_a.size()); end
        total++; if (w !== 16'h1234) begin bad++; $display("FAIL busy_data got=%h want=1234", w); end
        total++; if (done_a.size() != 1 || csf_a.size() != 1) begin
            bad++; $display("FAIL busy_frames done=%0d csfall=%0d want 1/1", done_a.size(), csf_a.size());
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        logic [15:0] w = '0;
        @(negedge clk);
        clear_a();
        bus_a.TX_DATA = 16'hFFFF; bus_a.TX_REQ = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        bus_a.TX_REQ = 1'b0;
        wait_until(t0 + 128);  // label 129: high phase of the 8th bit
        total++; if (bus_a.SPI_CS !== 1'b0 || bus_a.SPI_CLK !== 1'b1 || bus_a.SPI_MOSI !== 1'b1) begin
            bad++; $display("FAIL mid_pre cs/clk/mosi got=%b%b%b want=011", bus_a.SPI_CS, bus_a.SPI_CLK, bus_a.SPI_MOSI);
        end
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus_a.SPI_CS !== 1'b1 || bus_a.SPI_CLK !== 1'b0 || bus_a.SPI_MOSI !== 1'b0) begin
            bad++; $display("FAIL mid_rst cs/clk/mosi got=%b%b%b want=100", bus_a.SPI_CS, bus_a.SPI_CLK, bus_a.SPI_MOSI);
        end
        total++; if (bus_a.TX_DONE !== 1'b0 || bus_a.TX_RDY !== 1'b1) begin
            bad++; $display("FAIL mid_rst done/rdy got=%b%b want=01", bus_a.TX_DONE, bus_a.TX_RDY);
        end
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++; if (done_a.size() != 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", done_a.size()); end
        total++; if (bus_a.TX_RDY !== 1'b1 || bus_a.SPI_CS !== 1'b1) begin
            bad++; $display("FAIL mid_post rdy/cs got=%b%b want=11", bus_a.TX_RDY, bus_a.SPI_CS);
        end
        clear_a();
        bus_a.TX_DATA = 16'h00FF; bus_a.TX_REQ = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        bus_a.TX_REQ = 1'b0;
        wait_until(t0 + 280);
        for (int i = 0; i < 16; i++) if (i < bits_a.size()) w = {w[14:0], bits_a[i]};
        total++; if (rise_a.size() != 16 || w !== 16'h00FF) begin
            bad++; $display("FAIL mid_new_frame edges=%0d data=%h want 16/00ff", rise_a.size(), w);
        end
        total++; if (done_a.size() != 1 || done_a[0] - t0 + 1 != 265) begin
            bad++; $display("FAIL mid_new_done got=%0d want=265", done_a.size() ? done_a[0] - t0 + 1 : -1);
        end
    endtask

    task automatic test_small();
        int t0;
        logic [7:0] w = '0;
        @(negedge clk);
        bits_b.delete(); rise_b.delete(); done_b.delete(); rdyr_b.delete();
        bus_b.TX_DATA = 8'h5A; bus_b.TX_REQ = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        bus_b.TX_REQ = 1'b0;
        wait_until(t0 + 30);
        for (int i = 0; i < 8; i++) if (i < bits_b.size()) w = {w[6:0], bits_b[i]};
        total++; if (rise_b.size() != 8) begin bad++; $display("FAIL small_edges got=%0d want=8", rise_b.size()); end
        total++; if (w !== 8'h5A) begin bad++; $display("FAIL small_data got=%h want=5a", w); end
        total++; if (rise_b.size() != 8 || rise_b[0] - t0 + 1 != 3 || rise_b[7] - rise_b[0] != 14) begin
            bad++; $display("FAIL small_rise first=%0d want=3", rise_b.size() ? rise_b[0] - t0 + 1 : -1);
        end
        total++; if (done_b.size() != 1 || done_b[0] - t0 + 1 != 19) begin
            bad++; $display("FAIL small_done got=%0d want=19", done_b.size() ? done_b[0] - t0 + 1 : -1);
        end
        total++; if (rdyr_b.size() != 1 || rdyr_b[0] - t0 + 1 != 20) begin
            bad++; $display("FAIL small_rdy got=%0d want=20", rdyr_b.size() ? rdyr_b[0] - t0 + 1 : -1);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_busy();
        test_reset_mid();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ptmch_spi_mst.md
Name: ptmch_spi_mst

Overview:
SPI master (initiator) that serializes command words from the CLK160M domain onto SPI_CS/SPI_CLK/SPI_MOSI. It is the transmitting end of the SPI link consumed by the ptmch SPI receiver/trigger logic, and is used for board-level command injection and for loopback verification. Operation is mode 0 (CPOL=0, CPHA=0), MSB first, one word per chip-select frame.

Parameters:
P_DW, 16, frame width in bits (>=1)
P_CLKDIV, 8, SPI_CLK half-period in CLK160M cycles (>=1); default gives SPI_CLK = 10 MHz
P_CSGAP, 4, CS setup, CS hold and minimum CS-idle time in CLK160M cycles (>=1)

Ports:
CLK160M  input  1  system clock, 160 MHz; the only clock
RESET_N  input  1  asynchronous active-low reset
TX_REQ  input  1  request; word is accepted on a rising edge of CLK160M where TX_REQ=1 and TX_RDY=1
TX_DATA  input  P_DW  word to send; sampled only at acceptance
TX_RDY  output  1  block is idle and can accept a word
TX_DONE  output  1  one-cycle pulse when a frame completes (CS deasserts)
SPI_CS  output  1  chip select, active low, idle high
SPI_CLK  output  1  serial clock, idle low
SPI_MOSI  output  1  serial data, changes while SPI_CLK is low

Behaviour:
- Clock: one clock, CLK160M. Reset: RESET_N is asynchronous and active-low. All outputs are registered.
- Reset values: SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, TX_RDY=1, TX_DONE=0, state IDLE.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- Acceptance cycle T0:
  - Shift register <= TX_DATA.
  - Next cycle (T0+1): SPI_CS=0, SPI_MOSI=TX_DATA[P_DW-1], TX_RDY=0, state SETUP.
- SETUP: lasts P_CSGAP cycles, with SPI_CLK=0.
- SHIFT: each bit is SPI_CLK low for P_CLKDIV cycles, then high for P_CLKDIV cycles.
  - SPI_MOSI updates to the next bit at the first cycle of each low phase (except bit 0, already presented in SETUP).
  - Exactly P_DW rising edges per frame.
  - First rising edge at T0+1+P_CSGAP+P_CLKDIV.
- HOLD: starts after the last high phase. SPI_CLK=0, SPI_CS=0 for P_CSGAP cycles. SPI_MOSI keeps the last bit.
- GAP: SPI_CS=1 and SPI_MOSI=0 for P_CSGAP cycles. TX_DONE=1 on the first GAP cycle only.
- Return to IDLE: TX_RDY=1 on the cycle after GAP ends.
- Default frame timing (relative to T0):
  - CS low T0+1..T0+264
  - TX_DONE at T0+265
  - TX_RDY high at T0+269
- Back-to-back: TX_REQ held high is accepted on the first TX_RDY cycle. Minimum CS-high time is P_CSGAP+1 cycles.
- TX_REQ while TX_RDY=0 is ignored, with no queuing; the requester holds TX_REQ.
- TX_DATA changes after acceptance do not affect the frame in flight.
- Reset asserted mid-frame: outputs go immediately to reset values, with no TX_DONE, and the frame is abandoned.
- Counters:
  - Phase counter width $clog2(max(P_CLKDIV,P_CSGAP)+1).
  - Bit counter width $clog2(P_DW+1).
  - No wrap-around permitted; the terminal count moves the FSM.
- Elaboration fails (assertion) if any parameter is < 1.

Decomposition:
- Shared package ptmch_pkg:
  - FSM state enum typedef (ptmch_spi_st_e).
  - SPI mode constants (CPOL=0, CPHA=0, MSB-first).
  - Default P_DW/P_CLKDIV/P_CSGAP constants shared with the receiver.
- One sub-module, ptmch_spi_tick: a programmable down-counter producing a one-cycle terminal tick. It is loaded by the FSM with P_CLKDIV or P_CSGAP.

Test Plan:
- Default params, TX_DATA=16'hA5C3, one TX_REQ:
  - Bits sampled on SPI_CLK rising edges = A5C3, 16 rising edges.
  - First rising edge at T0+13; CS low T0+1..T0+264; TX_DONE single pulse at T0+265; TX_RDY high at T0+269.
- Back-to-back, TX_REQ held high with 16'h0001 then 16'h8000:
  - Two frames decoded correctly.
  - CS high exactly 5 cycles between them; two TX_DONE pulses 269 cycles apart.
- TX_REQ pulsed during a busy frame, plus TX_DATA changed to 16'hFFFF after acceptance of 16'h1234:
  - Only 16'h1234 is transmitted; no second frame.
- RESET_N asserted during bit 7 of a frame:
  - Same cycle: SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, no TX_DONE.
  - After release, TX_RDY=1 and a new 16'h00FF frame transmits cleanly.
- P_DW=8, P_CLKDIV=1, P_CSGAP=1, TX_DATA=8'h5A:
  - SPI_CLK 80 MHz, 8 rising edges, data 5A.
  - TX_DONE at T0+19; TX_RDY at T0+20.
- Idle check: no TX_REQ for 1000 cycles -> SPI_CS=1, SPI_CLK=0, SPI_MOSI=0 throughout, no TX_DONE.
